time_display: RTL and testbench

Multiplexed 8-digit seven-segment display driver on the read side of the clock/calendar counter chain. It snapshots the binary second/minute/hour or day/month/year fields once per frame. A sequential double-dabble engine converts the snapshot to BCD and commits it atomically to a display bank. The block scans the bank onto common-anode digits and blinks whichever field is under adjustment.

---
 rtl/time_display.sv | 239 +++++++++++++++++++++++
 tb/tb_time_display.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_display.sv
// Multiplexed 8-digit seven-segment driver for the clock/calendar read side.
// Snapshots the fields once per frame and converts them to BCD with a serial double-dabble engine.
module time_display #(
  parameter int unsigned SCAN_DIV  = 4,
  parameter int unsigned BLINK_DIV = 500
) (
  input  logic        clk_1kHz,
  input  logic        rst,
  input  logic        page,
  input  logic [5:0]  sec_bin,
  input  logic [5:0]  min_bin,
  input  logic [4:0]  hour_bin,
  input  logic [4:0]  day_bin,
  input  logic [3:0]  month_bin,
  input  logic [11:0] year_bin,
  input  logic        adjust_sec,
  input  logic        adjust_min,
  input  logic        adjust_hour,
  input  logic        adjust_day,
  input  logic        adjust_month,
  input  logic        adjust_year,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

  state_t state, state_d;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       idx;
  logic [BLK_W-1:0] blink_cnt;
  logic             phase;
  logic             snap_page;
  logic [5:0]       snap_sec, snap_min;
  logic [4:0]       snap_hour, snap_day;
  logic [3:0]       snap_month;
  logic [11:0]      snap_year;
  logic [1:0]       fld;
  logic [3:0]       sh_cnt;
  logic [11:0]      bin_sr;
  logic [15:0]      bcd;
  logic [31:0]      shadow;
  logic [31:0]      disp_bank;
  logic             disp_page;

  logic        frame_start_c;
  logic        last_shift_c;
  logic [11:0] field_load_c;
  logic [15:0] bcd_adj_c;
  logic [15:0] bcd_next_c;
  logic [2:0]  digit_c;
  logic [3:0]  code_c;
  logic        blink_field_c;
  logic        blanked_c;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    case (code)
      4'd0:      return 7'h40;
      4'd1:      return 7'h79;
      4'd2:      return 7'h24;
      4'd3:      return 7'h30;
      4'd4:      return 7'h19;
      4'd5:      return 7'h12;
      4'd6:      return 7'h02;
      4'd7:      return 7'h78;
      4'd8:      return 7'h00;
      4'd9:      return 7'h10;
      CODE_DASH: return 7'h3F;
      default:   return 7'h7F;
    endcase
  endfunction

  // Digit scan and blink timebases
  always_ff @(posedge clk_1kHz or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
        div_cnt <= '0;
        idx     <= idx + 3'd1;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BLK_W'(1);
      end
    end
  end

  assign frame_start_c = (idx == 3'd0) && (div_cnt == '0);
  assign last_shift_c  = (sh_cnt == ((snap_page && fld == 2'd2) ? 4'd11 : 4'd7));

  always_comb begin
    field_load_c = '0;
    case ({snap_page, fld})
      3'b000:  field_load_c = {3'b0, snap_hour, 4'b0};
      3'b001:  field_load_c = {2'b0, snap_min, 4'b0};
      3'b010:  field_load_c = {2'b0, snap_sec, 4'b0};
      3'b100:  field_load_c = {3'b0, snap_day, 4'b0};
      3'b101:  field_load_c = {4'b0, snap_month, 4'b0};
      3'b110:  field_load_c = snap_year;
      default: field_load_c = '0;
    endcase
  end

  // Double-dabble step: add 3 to nibbles >= 5, then shift in the next binary bit
  always_comb begin
    bcd_adj_c = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_next_c = {bcd_adj_c[14:0], bin_sr[11]};
  end

  always_ff @(posedge clk_1kHz or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (frame_start_c) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (last_shift_c) state_d = (fld == 2'd2) ? COMMIT : LOAD;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_1kHz or posedge rst) begin
    if (rst) begin
      snap_page  <= 1'b0;
      snap_sec   <= '0;
      snap_min   <= '0;
      snap_hour  <= '0;
      snap_day   <= '0;
      snap_month <= '0;
      snap_year  <= '0;
      fld        <= '0;
      sh_cnt     <= '0;
      bin_sr     <= '0;
      bcd        <= '0;
      shadow     <= {8{CODE_BLANK}};
      disp_bank  <= {8{CODE_BLANK}};
      disp_page  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (frame_start_c) begin
          snap_page  <= page;
          snap_sec   <= sec_bin;
          snap_min   <= min_bin;
          snap_hour  <= hour_bin;
          snap_day   <= day_bin;
          snap_month <= month_bin;
          snap_year  <= year_bin;
          fld        <= '0;
        end
        LOAD: begin
          bcd    <= '0;
          sh_cnt <= '0;
          bin_sr <= field_load_c;
        end
        SHIFT: begin
          bcd    <= bcd_next_c;
          bin_sr <= {bin_sr[10:0], 1'b0};
          sh_cnt <= sh_cnt + 4'd1;
          if (last_shift_c) begin
            fld <= fld + 2'd1;
            // Time page writes the separator dash along with hour and minute
            case ({snap_page, fld})
              3'b000:  shadow[31:20] <= {bcd_next_c[7:0], CODE_DASH};
              3'b001:  shadow[19:8]  <= {bcd_next_c[7:0], CODE_DASH};
              3'b010:  shadow[7:0]   <= bcd_next_c[7:0];
              3'b100:  shadow[31:24] <= bcd_next_c[7:0];
              3'b101:  shadow[23:16] <= bcd_next_c[7:0];
              3'b110:  shadow[15:0]  <= bcd_next_c;
              default: ;
            endcase
          end
        end
        COMMIT: begin
          disp_bank <= shadow;
          disp_page <= snap_page;
        end
        default: ;
      endcase
    end
  end

  assign digit_c = ~idx;
  assign code_c  = disp_bank[{digit_c, 2'b00} +: 4];

  // Live adjust flags select which committed-page field blinks
  always_comb begin
    blink_field_c = 1'b0;
    if (!disp_page) begin
      case (digit_c)
        3'd7, 3'd6: blink_field_c = adjust_hour;
        3'd4, 3'd3: blink_field_c = adjust_min;
        3'd1, 3'd0: blink_field_c = adjust_sec;
        default:    blink_field_c = 1'b0;
      endcase
    end else begin
      case (digit_c)
        3'd7, 3'd6: blink_field_c = adjust_day;
        3'd5, 3'd4: blink_field_c = adjust_month;
        default:    blink_field_c = adjust_year;
      endcase
    end
  end

  assign blanked_c = phase && blink_field_c;

  always_ff @(posedge clk_1kHz or posedge rst) begin
    if (rst) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= 8'hFF;
    end else begin
      seg <= blanked_c ? 7'h7F : seg_decode(code_c);
      dp  <= ~(disp_page && !blanked_c && (digit_c == 3'd6 || digit_c == 3'd4));
      an  <= ~(8'b1 << digit_c);
    end
  end

endmodule

// File: tb/tb_time_display.sv
// Self-checking bench for time_display: every cycle compares seg/dp/an against
// a reference model built from digit arithmetic and conversion latencies.
module tb_time_display;

  localparam int SCAN_DIV  = 1;
  localparam int BLINK_DIV = 4;

  logic        clk_1kHz = 1'b0;
  logic        rst = 1'b0;
  logic        page = 1'b0;
  logic [5:0]  sec_bin = '0, min_bin = '0;
  logic [4:0]  hour_bin = '0, day_bin = '0;
  logic [3:0]  month_bin = '0;
  logic [11:0] year_bin = '0;
  logic        adjust_sec = 0, adjust_min = 0, adjust_hour = 0;
  logic        adjust_day = 0, adjust_month = 0, adjust_year = 0;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;

  time_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk_1kHz(clk_1kHz), .rst(rst), .page(page),
    .sec_bin(sec_bin), .min_bin(min_bin), .hour_bin(hour_bin),
    .day_bin(day_bin), .month_bin(month_bin), .year_bin(year_bin),
    .adjust_sec(adjust_sec), .adjust_min(adjust_min), .adjust_hour(adjust_hour),
    .adjust_day(adjust_day), .adjust_month(adjust_month), .adjust_year(adjust_year),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk_1kHz = ~clk_1kHz;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: edge count since reset release, conversion schedule, committed values
  int edge_n = 0;
  bit busy = 0;
  int conv_start = 0;
  int commit_at = 0;
  bit d_valid = 0;
  bit d_page = 0;
  int d_sec, d_min, d_hour, d_day, d_month, d_year;
  bit s_page;
  int s_sec, s_min, s_hour, s_day, s_month, s_year;

  function automatic logic [6:0] glyph(int c);
    case (c)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  // Character on digit d: 0-9, 10 = dash, 15 = blank
  function automatic int char_of(int d);
    if (!d_valid) return 15;
    if (!d_page) begin
      case (d)
        7: return d_hour / 10;  6: return d_hour % 10;
        4: return d_min / 10;   3: return d_min % 10;
        1: return d_sec / 10;   0: return d_sec % 10;
        default: return 10;
      endcase
    end
    case (d)
      7: return d_day / 10;          6: return d_day % 10;
      5: return d_month / 10;        4: return d_month % 10;
      3: return d_year / 1000;       2: return (d_year / 100) % 10;
      1: return (d_year / 10) % 10;  default: return d_year % 10;
    endcase
  endfunction

  function automatic bit adjusting(int d);
    if (!d_page) begin
      if (d >= 6) return adjust_hour;
      if (d == 4 || d == 3) return adjust_min;
      if (d <= 1) return adjust_sec;
      return 0;
    end
    if (d >= 6) return adjust_day;
    if (d >= 4) return adjust_month;
    return adjust_year;
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at edge %0d: observed=%h expected=%h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_seg"}, {1'b0, seg}, 8'h7F);
    check({tag, "_dp"}, {7'b0, dp}, 8'h01);
    check({tag, "_an"}, an, 8'hFF);
  endtask

  task automatic model_reset();
    edge_n = 0; busy = 0; d_valid = 0; d_page = 0;
  endtask

  task automatic tick();
    int d, c;
    bit blank, ph;
    logic [6:0] e_seg;
    logic e_dp;
    @(posedge clk_1kHz);
    #1;
    edge_n++;
    d  = 7 - ((edge_n - 1) / SCAN_DIV) % 8;
    ph = (((edge_n - 1) / BLINK_DIV) % 2) == 1;
    c  = char_of(d);
    blank = ph && adjusting(d);
    e_seg = blank ? 7'h7F : glyph(c);
    e_dp  = !(d_page && !blank && (d == 6 || d == 4));
    check("an", an, ~(8'h01 << d));
    check("seg", {1'b0, seg}, {1'b0, e_seg});
    check("dp", {7'b0, dp}, {7'b0, e_dp});
    if (busy && edge_n == commit_at) begin
      busy = 0; d_valid = 1; d_page = s_page;
      d_sec = s_sec; d_min = s_min; d_hour = s_hour;
      d_day = s_day; d_month = s_month; d_year = s_year;
    end else if (!busy && ((edge_n - 1) % (8 * SCAN_DIV)) == 0) begin
      busy = 1; conv_start = edge_n; commit_at = edge_n + (page ? 32 : 28);
      s_page = page; s_sec = int'(sec_bin); s_min = int'(min_bin); s_hour = int'(hour_bin);
      s_day = int'(day_bin); s_month = int'(month_bin); s_year = int'(year_bin);
    end
  endtask

  task automatic run(int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic wait_conv_cycle(int k);
    int guard;
    guard = 0;
    while (!(busy && edge_n - conv_start == k) && guard < 200) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (guard >= 200) begin
      n_err++;
      $error("FAIL conv_wait: observed=timeout expected=conversion cycle %0d", k);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    @(posedge clk_1kHz); #1;
    check_reset_outputs("reset_held");
    rst = 1'b0;
    model_reset();

    // Time page, test-plan values
    hour_bin = 5'd23; min_bin = 6'd7; sec_bin = 6'd59; page = 1'b0;
    run(60);

    // Snapshot isolation: sec changes mid-conversion
    wait_conv_cycle(10);
    sec_bin = 6'd0;
    run(80);

    // Date page
    day_bin = 5'd29; month_bin = 4'd2; year_bin = 12'd2024; page = 1'b1;
    run(90);

    // Blink on time page; off-page adjust flag must be ignored
    page = 1'b0; sec_bin = 6'd59;
    run(50);
    adjust_min = 1'b1;
    run(40);
    adjust_min = 1'b0; adjust_year = 1'b1;
    run(30);
    adjust_year = 1'b0;

    // Bounds
    page = 1'b1; year_bin = 12'd3000;
    run(60);
    year_bin = 12'd4095;
    run(60);
    page = 1'b0; sec_bin = 6'd0;
    run(50);
    sec_bin = 6'd63;
    run(50);

    // Randomized fields, pages and adjust flags
    for (int it = 0; it < 25; it++) begin
      sec_bin   = 6'($urandom_range(0, 63));
      min_bin   = 6'($urandom_range(0, 63));
      hour_bin  = 5'($urandom_range(0, 31));
      day_bin   = 5'($urandom_range(0, 31));
      month_bin = 4'($urandom_range(0, 15));
      year_bin  = 12'($urandom_range(0, 4095));
      page      = 1'($urandom_range(0, 1));
      adjust_sec   = ($urandom_range(0, 3) == 0);
      adjust_min   = ($urandom_range(0, 3) == 0);
      adjust_hour  = ($urandom_range(0, 3) == 0);
      adjust_day   = ($urandom_range(0, 3) == 0);
      adjust_month = ($urandom_range(0, 3) == 0);
      adjust_year  = ($urandom_range(0, 3) == 0);
      run(int'($urandom_range(20, 80)));
    end
    {adjust_sec, adjust_min, adjust_hour, adjust_day, adjust_month, adjust_year} = '0;

    // Reset in the middle of a date conversion
    day_bin = 5'd29; month_bin = 4'd2; year_bin = 12'd2024; page = 1'b1;
    run(40);
    wait_conv_cycle(15);
    rst = 1'b1;
    #1 check_reset_outputs("mid_reset");
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_1kHz); #1;
      check_reset_outputs("mid_reset_held");
    end
    rst = 1'b0;
    run(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
